// File: rtl/arith_pkg.sv
// Shared types for the arithmetic block: divider FSM states, control word, default width.
package arith_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHIFT,
    DECIDE,
    DONE
  } div_state_t;

  typedef struct packed {
    logic load_M;
    logic load_Q;
    logic reset_A;
    logic shift_all;
    logic sub_A;
    logic restore_A;
    logic set_Q0;
  } div_control_t;

endpackage

// File: rtl/divider_fsm.sv
// Sequencer for the restoring divider: state register, bit counter and control-word decode.
module divider_fsm
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic         i_divisor_zero,
  input  logic         i_sub_neg,
  output div_control_t o_ctrl,
  output logic         o_accept,
  output logic         o_finish,
  output logic         o_zero_finish,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  div_state_t        r_state, w_state_next;
  logic [CntW-1:0]   r_cnt, w_cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= CntW'(WIDTH);
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    o_ctrl        = '0;
    o_accept      = 1'b0;
    o_finish      = 1'b0;
    o_zero_finish = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_valid) begin
          o_accept     = 1'b1;
          w_state_next = INIT;
        end
      end
      INIT: begin
        o_ctrl.load_M  = 1'b1;
        o_ctrl.load_Q  = 1'b1;
        o_ctrl.reset_A = 1'b1;
        w_cnt_next     = CntW'(WIDTH);
        if (i_divisor_zero) begin
          o_zero_finish = 1'b1;
          w_state_next  = DONE;
        end else begin
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        o_ctrl.shift_all = 1'b1;
        w_state_next     = DECIDE;
      end
      DECIDE: begin
        // A negative trial difference means the divisor did not fit: keep A, quotient bit 0.
        o_ctrl.sub_A     = 1'b1;
        o_ctrl.restore_A = i_sub_neg;
        o_ctrl.set_Q0    = ~i_sub_neg;
        w_cnt_next       = r_cnt - 1'b1;
        if (r_cnt == CntW'(1)) begin
          o_finish     = 1'b1;
          w_state_next = DONE;
        end else begin
          w_state_next = SHIFT;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == DONE);

endmodule

// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider: A/Q/M datapath and registered results.
module divider_unit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             div_DONE,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_control_t     w_ctrl;
  logic             w_accept, w_finish, w_zero_finish, w_sub_neg;
  logic [WIDTH:0]   r_a, w_a_next, w_diff;
  logic [WIDTH-1:0] r_q, w_q_next, r_m, w_m_next;
  logic [WIDTH-1:0] r_dividend, r_divisor, r_quotient, r_remainder;
  logic             r_dbz;

  assign w_diff    = r_a - {1'b0, r_m};
  assign w_sub_neg = w_diff[WIDTH];

  divider_fsm #(
    .WIDTH(WIDTH)
  ) u_fsm (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (valid),
    .i_divisor_zero(r_divisor == '0),
    .i_sub_neg     (w_sub_neg),
    .o_ctrl        (w_ctrl),
    .o_accept      (w_accept),
    .o_finish      (w_finish),
    .o_zero_finish (w_zero_finish),
    .o_busy        (busy),
    .o_done        (div_DONE)
  );

  always_comb begin
    w_a_next = r_a;
    w_q_next = r_q;
    w_m_next = r_m;
    if (w_ctrl.load_M)  w_m_next = r_divisor;
    if (w_ctrl.load_Q)  w_q_next = r_dividend;
    if (w_ctrl.reset_A) w_a_next = '0;
    if (w_ctrl.shift_all) begin
      w_a_next = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
      w_q_next = {r_q[WIDTH-2:0], 1'b0};
    end
    if (w_ctrl.sub_A && !w_ctrl.restore_A) w_a_next = w_diff;
    if (w_ctrl.set_Q0) w_q_next[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_a <= w_a_next;
      r_q <= w_q_next;
      r_m <= w_m_next;
      if (w_accept) begin
        r_dividend <= dividend;
        r_divisor  <= divisor;
        r_dbz      <= 1'b0;
      end
      // Results register on the edge into DONE so they are valid alongside div_DONE.
      if (w_finish) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_a_next[WIDTH-1:0];
      end
      if (w_zero_finish) begin
        r_quotient  <= '1;
        r_remainder <= r_dividend;
        r_dbz       <= 1'b1;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed scenarios plus randomized back-to-back divides.
module tb_divider_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [W-1:0] dividend, divisor;
  logic         busy, div_DONE, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  divider_unit #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .div_DONE   (div_DONE),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Reference: plain integer division; zero divisor yields all-ones and the dividend back.
  // Latency counts edges after the accepting edge until div_DONE is visible.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
    if (b == 0) begin
      q   = {W{1'b1}};
      r   = a;
      z   = 1'b1;
      lat = 1;
    end else begin
      q   = a / b;
      r   = a % b;
      z   = 1'b0;
      lat = 2 * W + 1;
    end
  endfunction

  // Called just after a clock edge; returns just after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    valid    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    valid    = 1'b0;
    dividend = W'($urandom_range(0, 255));
    divisor  = W'($urandom_range(0, 255));
  endtask

  task automatic wait_done(output int edges, output bit seen);
    seen  = 1'b0;
    edges = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (div_DONE) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    valid    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    n_checks++;
    if ({busy, div_DONE, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, expected all 0",
               busy, div_DONE, quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_not_busy: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat, edges;
    bit           seen;
    ref_div(8'd100, 8'd7, eq, er, ez, lat);
    start_op(8'd100, 8'd7);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b expected 1", busy);
    end
    wait_done(edges, seen);
    n_checks++;
    if (!seen || edges != lat) begin
      n_fail++;
      $display("FAIL basic_latency: got seen=%0d edges=%0d expected edges=%0d", seen, edges, lat);
    end
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
               quotient, remainder, div_by_zero, eq, er, ez);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({div_DONE, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_pulse: got done=%b busy=%b expected 0 0", div_DONE, busy);
    end
  endtask

  task automatic test_pairs(input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input logic [W-1:0] a1, input logic [W-1:0] b1);
    logic [W-1:0] as [2];
    logic [W-1:0] bs [2];
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat, edges;
    bit           seen;
    as[0] = a0; bs[0] = b0;
    as[1] = a1; bs[1] = b1;
    for (int k = 0; k < 2; k++) begin
      ref_div(as[k], bs[k], eq, er, ez, lat);
      start_op(as[k], bs[k]);
      wait_done(edges, seen);
      n_checks++;
      if (!seen || edges != lat) begin
        n_fail++;
        $display("FAIL pair_latency %0d/%0d: got seen=%0d edges=%0d expected edges=%0d",
                 as[k], bs[k], seen, edges, lat);
      end
      n_checks++;
      if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
        n_fail++;
        $display("FAIL pair_result %0d/%0d: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%b",
                 as[k], bs[k], quotient, remainder, div_by_zero, eq, er, ez);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignore_valid();
    int done_cnt  = 0;
    int done_edge = -1;
    logic [W-1:0] q_at, r_at;
    q_at = '0;
    r_at = '0;
    start_op(8'd100, 8'd7);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      #1;
      if (div_DONE) begin
        done_cnt++;
        done_edge = e;
        q_at = quotient;
        r_at = remainder;
      end
      // Pulses sampled at edges 5, 10 (busy) and 18 (the div_DONE cycle) must all be dropped.
      valid = (e == 4 || e == 9 || e == 17);
      dividend = 8'd3;
      divisor  = 8'd1;
    end
    valid = 1'b0;
    n_checks++;
    if (done_cnt != 1 || done_edge != 2 * W + 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d pulses at edge %0d expected 1 at edge %0d",
               done_cnt, done_edge, 2 * W + 1);
    end
    n_checks++;
    if ({q_at, r_at} !== {8'd14, 8'd2}) begin
      n_fail++;
      $display("FAIL ignore_result: got q=%0d r=%0d expected q=14 r=2", q_at, r_at);
    end
    n_checks++;
    if ({busy, quotient, remainder} !== {1'b0, 8'd14, 8'd2}) begin
      n_fail++;
      $display("FAIL ignore_held: got busy=%b q=%0d r=%0d expected busy=0 q=14 r=2",
               busy, quotient, remainder);
    end
  endtask

  task automatic test_reset_abort();
    int  done_cnt = 0;
    int  edges;
    bit  seen;
    start_op(8'd100, 8'd7);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, div_DONE, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, expected all 0",
               busy, div_DONE, quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      #1;
      if (div_DONE || busy) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", done_cnt);
    end
    start_op(8'd50, 8'd6);
    wait_done(edges, seen);
    n_checks++;
    if (!seen || {quotient, remainder, div_by_zero} !== {8'd8, 8'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_restart: got seen=%0d q=%0d r=%0d dbz=%b expected q=8 r=2 dbz=0",
               seen, quotient, remainder, div_by_zero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] a, b, eq, er;
    logic         ez;
    int           lat, edges;
    bit           seen;
    for (int k = 0; k < n; k++) begin
      a = W'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 8'd1;
        2:       b = 8'd255;
        3:       b = W'($urandom_range(1, 15));
        default: b = W'($urandom_range(1, 255));
      endcase
      ref_div(a, b, eq, er, ez, lat);
      start_op(a, b);
      wait_done(edges, seen);
      n_checks++;
      if (!seen || edges != lat) begin
        n_fail++;
        $display("FAIL rand_latency %0d/%0d: got seen=%0d edges=%0d expected edges=%0d",
                 a, b, seen, edges, lat);
      end
      n_checks++;
      if (quotient !== eq) begin
        n_fail++;
        $display("FAIL rand_quotient %0d/%0d: got %0d expected %0d", a, b, quotient, eq);
      end
      n_checks++;
      if (remainder !== er) begin
        n_fail++;
        $display("FAIL rand_remainder %0d/%0d: got %0d expected %0d", a, b, remainder, er);
      end
      n_checks++;
      if (div_by_zero !== ez) begin
        n_fail++;
        $display("FAIL rand_dbz %0d/%0d: got %b expected %b", a, b, div_by_zero, ez);
      end
      // Next start goes in the cycle right after the div_DONE cycle.
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pairs(8'd255, 8'd1, 8'd5, 8'd9);
    test_pairs(8'd200, 8'd0, 8'd10, 8'd3);
    test_ignore_valid();
    test_reset_abort();
    test_random(1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
